overlap_addr_gen: RTL and testbench

OVERLAP_ADDR_GEN -- requirements
Module: overlap_addr_gen

---
 rtl/ovl_pkg.sv | 15 +
 rtl/ovl_slot_table.sv | 54 +++++
 rtl/overlap_addr_gen.sv | 211 +++++++++++++++++++++
 tb/tb_overlap_addr_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ovl_pkg.sv
// Shared types and defaults for the overlap-add address generator.
package ovl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CUR  = 2'd1,
      PREV = 2'd2,
      DONE = 2'd3
   } ovl_state_e;

   localparam int unsigned OVL_WPB    = 4;
   localparam int unsigned OVL_BASE_W = 3;
   localparam logic [OVL_BASE_W-1:0] OVL_BASE = 3'b100;

endpackage

// File: rtl/ovl_slot_table.sv
// Per-channel frame slot counter and "previous frame exists" flag.
module ovl_slot_table #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned CH_W      = 1,
   parameter int unsigned SLOT_BITS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CH_W-1:0]      rd_ch,
   output logic [SLOT_BITS-1:0] rd_slot_c,
   output logic                 rd_has_prev_c,
   input  logic                 upd_en,
   input  logic [CH_W-1:0]      upd_ch
);

   logic [SLOT_BITS-1:0] slot_cnt_q [NUM_CH];
   logic [SLOT_BITS-1:0] slot_cnt_d [NUM_CH];
   logic                 has_prev_q [NUM_CH];
   logic                 has_prev_d [NUM_CH];

   always_comb begin
      rd_slot_c     = '0;
      rd_has_prev_c = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_W'(i)) begin
            rd_slot_c     = slot_cnt_q[i];
            rd_has_prev_c = has_prev_q[i];
         end
      end
   end

   // Slot counter wraps naturally at 2^SLOT_BITS.
   always_comb begin
      slot_cnt_d = slot_cnt_q;
      has_prev_d = has_prev_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (upd_en && (upd_ch == CH_W'(i))) begin
            slot_cnt_d[i] = slot_cnt_q[i] + SLOT_BITS'(1);
            has_prev_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt_q <= '{default: '0};
         has_prev_q <= '{default: 1'b0};
      end else begin
         slot_cnt_q <= slot_cnt_d;
         has_prev_q <= has_prev_d;
      end
   end

endmodule

// File: rtl/overlap_addr_gen.sv
// Overlap memory address generator: current/previous window read pairs per frame.
// Eight-short window mode is built only when OVL_SHORT_WIN_EN is defined.
module overlap_addr_gen
   import ovl_pkg::*;
#(
   parameter int unsigned WIN_LEN   = 1024,
   parameter int unsigned WPB       = OVL_WPB,
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned SLOT_BITS = 2,
   parameter int unsigned BASE_W    = OVL_BASE_W,
   parameter logic [BASE_W-1:0] BASE = BASE_W'(OVL_BASE),
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned OFF_W  = $clog2(WIN_LEN),
   localparam int unsigned ADDR_W = BASE_W + CH_W + SLOT_BITS + OFF_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic              short_win,
   input  logic              addr_ready,
   output logic              addr_valid,
   output logic [ADDR_W-1:0] addr,
   output logic              do_overlap,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned HALF_LEN  = WIN_LEN / 2;
   localparam int unsigned SHORT_LEN = WIN_LEN / 8;
   localparam logic [OFF_W-1:0] STEP        = OFF_W'(WPB);
   localparam logic [OFF_W-1:0] LONG_W_MAX  = OFF_W'(HALF_LEN - WPB);
   localparam logic [OFF_W-1:0] SHORT_W_MAX = OFF_W'(SHORT_LEN / 2 - WPB);

   ovl_state_e           state_q, state_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [SLOT_BITS-1:0] slot_q, slot_d;
   logic                 prev_q, prev_d;
   logic                 short_q, short_d;
   logic [2:0]           k_q, k_d;
   logic [OFF_W-1:0]     w_q, w_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 addr_valid_q, addr_valid_d;
   logic                 do_overlap_q, do_overlap_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;

   logic [SLOT_BITS-1:0] rd_slot_c;
   logic                 rd_has_prev_c;
   logic                 upd_en_c;
   logic                 beat_c;
   logic                 last_c;
   logic                 pair_done_c;
   logic [OFF_W-1:0]     w_max_c;
   logic [OFF_W-1:0]     cur_off_c;
   logic [OFF_W-1:0]     prev_off_c;
   logic                 prev_old_slot_c;
   logic [SLOT_BITS-1:0] prev_slot_c;

`ifndef OVL_SHORT_WIN_EN
   logic unused_short_win;
   assign unused_short_win = short_win;
`endif

   ovl_slot_table #(
      .NUM_CH   (NUM_CH),
      .CH_W     (CH_W),
      .SLOT_BITS(SLOT_BITS)
   ) u_slot_table (
      .clk          (clk),
      .reset        (reset),
      .rd_ch        (ch_sel),
      .rd_slot_c    (rd_slot_c),
      .rd_has_prev_c(rd_has_prev_c),
      .upd_en       (upd_en_c),
      .upd_ch       (ch_q)
   );

   assign beat_c  = addr_valid_q && addr_ready;
   assign w_max_c = short_q ? SHORT_W_MAX : LONG_W_MAX;
   assign last_c  = (w_q == w_max_c) && (!short_q || (k_q == 3'd7));

   // Next state; outputs are registered from the next-state values.
   always_comb begin
      state_d         = state_q;
      ch_d            = ch_q;
      slot_d          = slot_q;
      prev_d          = prev_q;
      short_d         = short_q;
      k_d             = k_q;
      w_d             = w_q;
      upd_en_c        = 1'b0;
      pair_done_c     = 1'b0;
      cur_off_c       = '0;
      prev_off_c      = '0;
      prev_old_slot_c = 1'b1;
      prev_slot_c     = '0;
      addr_d          = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CUR;
               ch_d    = ch_sel;
               slot_d  = rd_slot_c;
               prev_d  = rd_has_prev_c;
`ifdef OVL_SHORT_WIN_EN
               short_d = short_win;
`else
               short_d = 1'b0;
`endif
               k_d     = '0;
               w_d     = '0;
            end
         end
         CUR: begin
            if (beat_c) begin
               if (prev_q) begin
                  state_d = PREV;
               end else begin
                  pair_done_c = 1'b1;
                  state_d     = last_c ? DONE : CUR;
               end
            end
         end
         PREV: begin
            if (beat_c) begin
               pair_done_c = 1'b1;
               state_d     = last_c ? DONE : CUR;
            end
         end
         DONE: begin
            state_d  = IDLE;
            upd_en_c = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (pair_done_c) begin
         if (w_q == w_max_c) begin
            w_d = '0;
            k_d = k_q + 3'd1;
         end else begin
            w_d = w_q + STEP;
         end
      end

      // Short window k pairs with the second half of window k-1; k=0 reaches into the previous frame.
      prev_slot_c = slot_d - SLOT_BITS'(1);
      if (short_d) begin
         cur_off_c = OFF_W'(k_d) * OFF_W'(SHORT_LEN) + w_d;
         if (k_d == 3'd0) begin
            prev_off_c = OFF_W'(WIN_LEN - SHORT_LEN / 2) + w_d;
         end else begin
            prev_off_c      = OFF_W'(k_d - 3'd1) * OFF_W'(SHORT_LEN) + OFF_W'(SHORT_LEN / 2) + w_d;
            prev_old_slot_c = 1'b0;
         end
      end else begin
         cur_off_c  = w_d;
         prev_off_c = OFF_W'(HALF_LEN) + w_d;
      end

      if (state_d == CUR) begin
         addr_d = {BASE, ch_d, slot_d, cur_off_c};
      end else if (state_d == PREV) begin
         addr_d = {BASE, ch_d, (prev_old_slot_c ? prev_slot_c : slot_d), prev_off_c};
      end

      addr_valid_d = (state_d == CUR) || (state_d == PREV);
      do_overlap_d = (state_d == PREV) || ((state_d == CUR) && !prev_d);
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ch_q         <= '0;
         slot_q       <= '0;
         prev_q       <= 1'b0;
         short_q      <= 1'b0;
         k_q          <= '0;
         w_q          <= '0;
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
         do_overlap_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         slot_q       <= slot_d;
         prev_q       <= prev_d;
         short_q      <= short_d;
         k_q          <= k_d;
         w_q          <= w_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
         do_overlap_q <= do_overlap_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign addr_valid = addr_valid_q;
   assign addr       = addr_q;
   assign do_overlap = do_overlap_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_overlap_addr_gen.sv
// Directed scoreboard bench for overlap_addr_gen (default parameters).
module tb_overlap_addr_gen;

   typedef struct packed {
      logic [15:0] addr;
      logic        dov;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [0:0]  ch_sel;
   logic        short_win;
   logic        addr_ready;
   logic        addr_valid;
   logic [15:0] addr;
   logic        do_overlap;
   logic        busy;
   logic        frame_done;

   int checks;
   int errors;

   exp_t       sb[$];
   logic [1:0] m_slot [2];
   logic       m_prev [2];
   logic [15:0] first_a;
   logic [15:0] second_a;
   logic        first_d;

   overlap_addr_gen dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ch_sel    (ch_sel),
      .short_win (short_win),
      .addr_ready(addr_ready),
      .addr_valid(addr_valid),
      .addr      (addr),
      .do_overlap(do_overlap),
      .busy      (busy),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(addr_valid), 32'd0);
      check({tag, "_addr"},  32'(addr),       32'd0);
      check({tag, "_dov"},   32'(do_overlap), 32'd0);
      check({tag, "_busy"},  32'(busy),       32'd0);
      check({tag, "_done"},  32'(frame_done), 32'd0);
   endtask

   function automatic logic [15:0] mk(input logic [0:0] ch, input logic [1:0] s, input int off);
      return {3'b100, ch, s, 10'(off)};
   endfunction

   function automatic void push_frame(input logic [0:0] ch, input logic sw);
      logic [1:0] s;
      logic [1:0] ps;
      logic       short_mode;
      logic       p;
      s  = m_slot[ch];
      ps = s - 2'd1;
      p  = m_prev[ch];
      short_mode = sw;
`ifndef OVL_SHORT_WIN_EN
      short_mode = 1'b0;
`endif
      if (!short_mode) begin
         for (int w = 0; w < 512; w += 4) begin
            sb.push_back(exp_t'{mk(ch, s, w), !p});
            if (p) sb.push_back(exp_t'{mk(ch, ps, 512 + w), 1'b1});
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < 64; w += 4) begin
               sb.push_back(exp_t'{mk(ch, s, k * 128 + w), !p});
               if (p) begin
                  if (k == 0) sb.push_back(exp_t'{mk(ch, ps, 960 + w), 1'b1});
                  else        sb.push_back(exp_t'{mk(ch, s, (k - 1) * 128 + 64 + w), 1'b1});
               end
            end
         end
      end
   endfunction

   task automatic run_frame(input logic [0:0] ch, input logic sw, input int stall_at, input int abort_at);
      int          beats;
      int          budget;
      logic        stalled;
      logic        aborted;
      logic [15:0] held_a;
      logic        held_d;
      exp_t        e;
      beats   = 0;
      budget  = 0;
      stalled = 1'b0;
      aborted = 1'b0;
      @(negedge clk);
      start      = 1'b1;
      ch_sel     = ch;
      short_win  = sw;
      addr_ready = 1'b1;
      push_frame(ch, sw);
      @(negedge clk);
      start = 1'b0;
      check("start_busy",  32'(busy),       32'd1);
      check("start_valid", 32'(addr_valid), 32'd1);
      while (sb.size() > 0 && budget < 4000) begin
         budget++;
         if (beats == abort_at) begin
            aborted = 1'b1;
            break;
         end
         if (beats == stall_at && !stalled) begin
            stalled    = 1'b1;
            held_a     = addr;
            held_d     = do_overlap;
            addr_ready = 1'b0;
            start      = 1'b1;
            ch_sel     = ~ch;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               start = 1'b0;
               check("stall_addr",  32'(addr),       32'(held_a));
               check("stall_dov",   32'(do_overlap), 32'(held_d));
               check("stall_valid", 32'(addr_valid), 32'd1);
            end
            ch_sel     = ch;
            addr_ready = 1'b1;
         end
         if (addr_valid) begin
            e = sb.pop_front();
            check("beat_addr", 32'(addr),       32'(e.addr));
            check("beat_dov",  32'(do_overlap), 32'(e.dov));
            if (beats == 0) begin
               first_a = addr;
               first_d = do_overlap;
            end
            if (beats == 1) second_a = addr;
            beats++;
         end
         @(negedge clk);
      end
      if (aborted) begin
         reset = 1'b1;
         sb.delete();
         m_slot = '{default: 2'd0};
         m_prev = '{default: 1'b0};
         @(negedge clk);
         check_zero("abort");
         @(negedge clk);
         reset = 1'b0;
         return;
      end
      check("frame_left", 32'(sb.size()), 32'd0);
      check("done_pulse", 32'(frame_done), 32'd1);
      check("done_busy",  32'(busy),       32'd1);
      check("done_valid", 32'(addr_valid), 32'd0);
      start  = 1'b1;
      ch_sel = ch;
      @(negedge clk);
      start = 1'b0;
      check("idle_done",  32'(frame_done), 32'd0);
      check("idle_busy",  32'(busy),       32'd0);
      check("idle_valid", 32'(addr_valid), 32'd0);
      m_slot[ch] = m_slot[ch] + 2'd1;
      m_prev[ch] = 1'b1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      start      = 1'b0;
      ch_sel     = 1'b0;
      short_win  = 1'b0;
      addr_ready = 1'b1;
      first_a    = '0;
      second_a   = '0;
      first_d    = 1'b0;
      m_slot     = '{default: 2'd0};
      m_prev     = '{default: 1'b0};
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      run_frame(1'b0, 1'b0, -1, -1);
      check("f1_first",     32'(first_a), 32'h8000);
      check("f1_first_dov", 32'(first_d), 32'd1);

      run_frame(1'b0, 1'b1, -1, -1);
      check("f2_first", 32'(first_a), 32'h8400);
`ifdef OVL_SHORT_WIN_EN
      check("f2_second", 32'(second_a), 32'h83C0);
`else
      check("f2_second", 32'(second_a), 32'h8200);
`endif

      run_frame(1'b1, 1'b0, -1, -1);
      check("ch1_first",     32'(first_a), 32'h9000);
      check("ch1_first_dov", 32'(first_d), 32'd1);

      run_frame(1'b0, 1'b0, 20, -1);
      run_frame(1'b0, 1'b0, -1, -1);
      run_frame(1'b0, 1'b0, -1, -1);
      check("wrap_cur",  32'(first_a),  32'h8000);
      check("wrap_prev", 32'(second_a), 32'h8E00);

      run_frame(1'b1, 1'b0, -1, 50);
      run_frame(1'b0, 1'b0, -1, -1);
      check("post_rst_first",     32'(first_a), 32'h8000);
      check("post_rst_first_dov", 32'(first_d), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
